jtkcpu_stack: RTL and testbench

Push/pull sequencer for the KONAMI-1 CPU. Started by the microcode sequencer's `psh_go`/`pul_go` pulses, it walks a 6809-style register postbyte mask and issues one stack byte transfer per `cen` cycle. It drives the stack address and data toward the bus, returns pulled bytes to the register file, and hands the updated S/U pointer back to the datapath. While `busy` is high the microcode holds its address.

---
 rtl/jtkcpu_pkg.sv | 24 ++
 rtl/jtkcpu_stack_enc.sv | 27 ++
 rtl/jtkcpu_stack.sv | 215 +++++++++++++++++++++
 tb/tb_jtkcpu_stack.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtkcpu_pkg.sv
// Shared KONAMI-1 definitions: register indices, register widths and
// stack sequencer state encodings.
package jtkcpu_pkg;

   localparam logic [2:0] REG_CC = 3'd0;
   localparam logic [2:0] REG_A  = 3'd1;
   localparam logic [2:0] REG_B  = 3'd2;
   localparam logic [2:0] REG_DP = 3'd3;
   localparam logic [2:0] REG_X  = 3'd4;
   localparam logic [2:0] REG_Y  = 3'd5;
   localparam logic [2:0] REG_US = 3'd6;
   localparam logic [2:0] REG_PC = 3'd7;

   // Bit n set: register index n is 16 bits wide
   localparam logic [7:0] REG_WIDE = 8'b1111_0000;

   typedef enum logic [1:0] {
      StIdle,
      StFirst,
      StSecond,
      StDone
   } stack_st_e;

endpackage

// File: rtl/jtkcpu_stack_enc.sv
// Picks the next register to transfer from the remaining postbyte mask:
// highest set bit when pushing, lowest set bit when pulling.
module jtkcpu_stack_enc
   import jtkcpu_pkg::*;
(
   input  logic [7:0] mask,
   input  logic       push,
   output logic [2:0] idx,
   output logic       valid
);

   always_comb begin
      idx = REG_CC;
      if (push) begin
         // Later matches overwrite earlier ones, so the highest set bit wins
         for (int i = 0; i < 8; i++) begin
            if (mask[i]) idx = 3'(i);
         end
      end else begin
         for (int i = 7; i >= 0; i--) begin
            if (mask[i]) idx = 3'(i);
         end
      end
      valid = |mask;
   end

endmodule

// File: rtl/jtkcpu_stack.sv
// Push/pull sequencer: walks a 6809-style postbyte mask and moves one stack
// byte per cen cycle, returning pulled bytes and the final stack pointer.
module jtkcpu_stack
   import jtkcpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        cen,
   input  logic        psh_go,
   input  logic        pul_go,
   input  logic [7:0]  mask,
   input  logic [15:0] sp_in,
   input  logic [7:0]  cc,
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   input  logic [7:0]  dp,
   input  logic [15:0] x,
   input  logic [15:0] y,
   input  logic [15:0] us,
   input  logic [15:0] pc,
   input  logic [7:0]  din,
   output logic        busy,
   output logic        done,
   output logic [15:0] addr,
   output logic [7:0]  dout,
   output logic        we,
   output logic        rd,
   output logic        pul_we,
   output logic [2:0]  pul_sel,
   output logic        pul_hi,
   output logic [7:0]  pul_data,
   output logic [15:0] sp_out,
   output logic        sp_upd
);

   stack_st_e   st_q, st_d;
   logic        push_q, push_d;
   logic [7:0]  mask_q, mask_d;
   logic [2:0]  cur_q, cur_d;
   logic [15:0] sp_q, sp_d;
   logic [15:0] addr_q, addr_d;
   logic [7:0]  dout_q, dout_d;
   logic        we_q, we_d;
   logic        rd_q, rd_d;
   logic [2:0]  sel_q, sel_d;
   logic        hi_q, hi_d;

   logic        go;
   logic        enc_dir;
   logic [7:0]  enc_mask;
   logic [2:0]  enc_idx;
   logic        enc_valid;
   logic [7:0]  mask_clr;
   logic [15:0] sp_base;
   logic [15:0] nb_addr;
   logic [15:0] nb_sp;
   logic        ld;
   logic        adv;
   logic [2:0]  ld_idx;
   logic        ld_second;
   logic [7:0]  push_byte;

   assign go       = psh_go | pul_go;
   assign mask_clr = mask_q & ~(8'b1 << cur_q);

   // In IDLE the encoder looks at the incoming request, otherwise at what is left
   assign enc_mask = (st_q == StIdle) ? mask   : mask_clr;
   assign enc_dir  = (st_q == StIdle) ? psh_go : push_q;
   assign sp_base  = (st_q == StIdle) ? sp_in  : sp_q;

   assign nb_addr  = enc_dir ? sp_base - 16'd1 : sp_base;
   assign nb_sp    = enc_dir ? sp_base - 16'd1 : sp_base + 16'd1;

   jtkcpu_stack_enc u_enc (
      .mask  (enc_mask),
      .push  (enc_dir),
      .idx   (enc_idx),
      .valid (enc_valid)
   );

   // Decide whether a new byte is scheduled on this cen edge, and which one
   always_comb begin
      ld        = 1'b0;
      adv       = 1'b0;
      ld_idx    = enc_idx;
      ld_second = 1'b0;
      unique case (st_q)
         StIdle:   ld = go & enc_valid;
         StFirst: begin
            if (REG_WIDE[cur_q]) begin
               ld        = 1'b1;
               ld_idx    = cur_q;
               ld_second = 1'b1;
            end else begin
               adv = 1'b1;
            end
         end
         StSecond: adv = 1'b1;
         StDone:   ld  = 1'b0;
         default:  ld  = 1'b0;
      endcase
      if (adv) ld = enc_valid;
   end

   // Pushes send the low byte of a 16-bit register first
   always_comb begin
      unique case (ld_idx)
         REG_CC:  push_byte = cc;
         REG_A:   push_byte = a;
         REG_B:   push_byte = b;
         REG_DP:  push_byte = dp;
         REG_X:   push_byte = ld_second ? x[15:8]  : x[7:0];
         REG_Y:   push_byte = ld_second ? y[15:8]  : y[7:0];
         REG_US:  push_byte = ld_second ? us[15:8] : us[7:0];
         REG_PC:  push_byte = ld_second ? pc[15:8] : pc[7:0];
         default: push_byte = 8'h00;
      endcase
   end

   always_comb begin
      st_d   = st_q;
      push_d = push_q;
      mask_d = mask_q;
      cur_d  = cur_q;
      sp_d   = sp_q;
      addr_d = addr_q;
      dout_d = dout_q;
      we_d   = we_q;
      rd_d   = rd_q;
      sel_d  = sel_q;
      hi_d   = hi_q;

      unique case (st_q)
         StIdle: begin
            if (go) begin
               push_d = psh_go;
               mask_d = mask;
               sp_d   = sp_in;
               st_d   = enc_valid ? StFirst : StDone;
               cur_d  = enc_idx;
            end
         end
         StFirst:  if (REG_WIDE[cur_q]) st_d = StSecond;
         StSecond: st_d = st_q;
         StDone:   st_d = StIdle;
         default:  st_d = StIdle;
      endcase

      if (adv) begin
         mask_d = mask_clr;
         if (enc_valid) begin
            st_d  = StFirst;
            cur_d = enc_idx;
         end else begin
            st_d = StDone;
            we_d = 1'b0;
            rd_d = 1'b0;
         end
      end

      if (ld) begin
         addr_d = nb_addr;
         sp_d   = nb_sp;
         we_d   = enc_dir;
         rd_d   = ~enc_dir;
         sel_d  = ld_idx;
         // Pulls fetch the high byte of a 16-bit register first
         hi_d   = ~enc_dir & ~ld_second & REG_WIDE[ld_idx];
         if (enc_dir) dout_d = push_byte;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q   <= StIdle;
         push_q <= 1'b0;
         mask_q <= 8'h00;
         cur_q  <= 3'd0;
         sp_q   <= 16'h0000;
         addr_q <= 16'h0000;
         dout_q <= 8'h00;
         we_q   <= 1'b0;
         rd_q   <= 1'b0;
         sel_q  <= 3'd0;
         hi_q   <= 1'b0;
      end else if (cen) begin
         st_q   <= st_d;
         push_q <= push_d;
         mask_q <= mask_d;
         cur_q  <= cur_d;
         sp_q   <= sp_d;
         addr_q <= addr_d;
         dout_q <= dout_d;
         we_q   <= we_d;
         rd_q   <= rd_d;
         sel_q  <= sel_d;
         hi_q   <= hi_d;
      end
   end

   // Strobes are qualified by rst so an aborted transfer commits nothing
   assign busy     = (st_q == StFirst) || (st_q == StSecond);
   assign done     = cen & ~rst & (st_q == StDone);
   assign sp_upd   = done;
   assign sp_out   = sp_q;
   assign addr     = addr_q;
   assign dout     = dout_q;
   assign we       = we_q;
   assign rd       = rd_q;
   assign pul_we   = cen & ~rst & rd_q;
   assign pul_sel  = sel_q;
   assign pul_hi   = hi_q;
   assign pul_data = rd_q ? din : 8'h00;

endmodule

// File: tb/tb_jtkcpu_stack.sv
// Bench for jtkcpu_stack: a byte-level stack model feeds an expected-transfer
// queue that a single negedge process checks against the DUT every cycle.
module tb_jtkcpu_stack;

   typedef struct packed {
      logic [15:0] addr;
      logic [7:0]  data;
      logic [2:0]  sel;
      logic        hi;
      logic        psh;
   } byte_t;

   logic        clk = 1'b0;
   logic        rst, cen, psh_go, pul_go;
   logic [7:0]  mask;
   logic [15:0] sp_in;
   logic [7:0]  cc, a, b, dp;
   logic [15:0] x, y, us, pc;
   logic [7:0]  din;
   logic        busy, done, we, rd, pul_we, pul_hi, sp_upd;
   logic [15:0] addr, sp_out;
   logic [7:0]  dout, pul_data;
   logic [2:0]  pul_sel;

   logic [7:0]  bus_mem [0:65535];
   logic [7:0]  mdl_mem [0:65535];
   byte_t       exp_q [$];
   byte_t       cur_e;
   logic [15:0] exp_sp;
   bit          arm = 1'b0, active = 1'b0;
   int          checks = 0, fails = 0;
   int          ncen;

   bit          prev_ok = 1'b0, prev_cen, prev_rst;
   logic [15:0] p_addr;
   logic [7:0]  p_dout;
   logic        p_we, p_rd, p_busy;

   always #5 clk = ~clk;

   jtkcpu_stack dut (
      .clk      (clk),
      .rst      (rst),
      .cen      (cen),
      .psh_go   (psh_go),
      .pul_go   (pul_go),
      .mask     (mask),
      .sp_in    (sp_in),
      .cc       (cc),
      .a        (a),
      .b        (b),
      .dp       (dp),
      .x        (x),
      .y        (y),
      .us       (us),
      .pc       (pc),
      .din      (din),
      .busy     (busy),
      .done     (done),
      .addr     (addr),
      .dout     (dout),
      .we       (we),
      .rd       (rd),
      .pul_we   (pul_we),
      .pul_sel  (pul_sel),
      .pul_hi   (pul_hi),
      .pul_data (pul_data),
      .sp_out   (sp_out),
      .sp_upd   (sp_upd)
   );

   assign din = bus_mem[addr];

   always @(posedge clk) begin
      if (!rst && cen && we) bus_mem[addr] <= dout;
   end

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endfunction

   function automatic logic [15:0] regval(input int r);
      case (r)
         0: return {8'h00, cc};
         1: return {8'h00, a};
         2: return {8'h00, b};
         3: return {8'h00, dp};
         4: return x;
         5: return y;
         6: return us;
         default: return pc;
      endcase
   endfunction

   function automatic void emit(input bit psh, input logic [15:0] ad, input logic [7:0] d,
                                input int r, input bit hi);
      byte_t e;
      e.addr = ad;
      e.data = d;
      e.sel  = 3'(r);
      e.hi   = hi;
      e.psh  = psh;
      exp_q.push_back(e);
      if (psh) mdl_mem[ad] = d;
   endfunction

   // Stack model: push walks PC..CC storing low byte at the higher address,
   // pull walks CC..PC reading high byte first.
   task automatic build(input bit psh, input logic [7:0] m, input logic [15:0] sp);
      logic [15:0] p;
      logic [15:0] v;
      exp_q.delete();
      p = sp;
      if (psh) begin
         for (int r = 7; r >= 0; r--) begin
            if (m[r]) begin
               v = regval(r);
               p = p - 16'd1;
               emit(1'b1, p, v[7:0], r, 1'b0);
               if (r >= 4) begin
                  p = p - 16'd1;
                  emit(1'b1, p, v[15:8], r, 1'b1);
               end
            end
         end
      end else begin
         for (int r = 0; r < 8; r++) begin
            if (m[r]) begin
               emit(1'b0, p, mdl_mem[p], r, r >= 4);
               p = p + 16'd1;
               if (r >= 4) begin
                  emit(1'b0, p, mdl_mem[p], r, 1'b0);
                  p = p + 16'd1;
               end
            end
         end
      end
      exp_sp = p;
   endtask

   task automatic run(input bit psh, input logic [7:0] m, input logic [15:0] sp,
                      input bit toggle, output int nc);
      int n;
      n  = 0;
      nc = 0;
      @(posedge clk); #1;
      psh_go = psh; pul_go = !psh; mask = m; sp_in = sp; cen = 1'b1; arm = 1'b1;
      @(posedge clk); #1;
      psh_go = 1'b0; pul_go = 1'b0; mask = 8'h00; sp_in = 16'hDEAD;
      while ((arm || active) && n < 400) begin
         cen    = toggle ? n[0] : 1'b1;
         psh_go = toggle && (n == 5);
         if (cen) nc++;
         @(posedge clk); #1;
         n++;
      end
      psh_go = 1'b0;
      cen    = 1'b1;
      chk("timeout", 32'(n >= 400), 32'd0);
   endtask

   always @(negedge clk) begin
      if (prev_ok && !prev_cen && !prev_rst) begin
         chk("hold_addr", 32'(addr), 32'(p_addr));
         chk("hold_dout", 32'(dout), 32'(p_dout));
         chk("hold_we",   32'(we),   32'(p_we));
         chk("hold_rd",   32'(rd),   32'(p_rd));
         chk("hold_busy", 32'(busy), 32'(p_busy));
      end
      if (rst) begin
         chk("rst_pul_we", 32'(pul_we), 32'd0);
         chk("rst_sp_upd", 32'(sp_upd), 32'd0);
         chk("rst_done",   32'(done),   32'd0);
         exp_q.delete();
         active = 1'b0;
         arm    = 1'b0;
      end else if (!cen) begin
         chk("nocen_pul_we", 32'(pul_we), 32'd0);
         chk("nocen_done",   32'(done),   32'd0);
         chk("nocen_sp_upd", 32'(sp_upd), 32'd0);
      end else if (arm) begin
         chk("go_busy", 32'(busy), 32'd0);
         arm    = 1'b0;
         active = 1'b1;
      end else if (active) begin
         if (exp_q.size() > 0) begin
            cur_e = exp_q.pop_front();
            chk("xfer_busy", 32'(busy), 32'd1);
            chk("xfer_done", 32'(done), 32'd0);
            chk("xfer_we",   32'(we),   32'(cur_e.psh));
            chk("xfer_rd",   32'(rd),   32'(!cur_e.psh));
            chk("xfer_addr", 32'(addr), 32'(cur_e.addr));
            if (cur_e.psh) begin
               chk("push_dout",   32'(dout),   32'(cur_e.data));
               chk("push_pul_we", 32'(pul_we), 32'd0);
            end else begin
               chk("pull_we",   32'(pul_we),   32'd1);
               chk("pull_sel",  32'(pul_sel),  32'(cur_e.sel));
               chk("pull_hi",   32'(pul_hi),   32'(cur_e.hi));
               chk("pull_data", 32'(pul_data), 32'(cur_e.data));
            end
         end else begin
            chk("done",        32'(done),   32'd1);
            chk("done_sp_upd", 32'(sp_upd), 32'd1);
            chk("done_sp_out", 32'(sp_out), 32'(exp_sp));
            chk("done_busy",   32'(busy),   32'd0);
            chk("done_we",     32'(we),     32'd0);
            chk("done_rd",     32'(rd),     32'd0);
            active = 1'b0;
         end
      end else begin
         chk("idle_busy",   32'(busy),   32'd0);
         chk("idle_done",   32'(done),   32'd0);
         chk("idle_sp_upd", 32'(sp_upd), 32'd0);
         chk("idle_we",     32'(we),     32'd0);
         chk("idle_rd",     32'(rd),     32'd0);
         chk("idle_pul_we", 32'(pul_we), 32'd0);
      end
      prev_ok  = 1'b1;
      prev_cen = cen;
      prev_rst = rst;
      p_addr   = addr;
      p_dout   = dout;
      p_we     = we;
      p_rd     = rd;
      p_busy   = busy;
   end

   initial begin
      rst = 1'b1; cen = 1'b0; psh_go = 1'b0; pul_go = 1'b0; mask = 8'h00; sp_in = 16'h0000;
      cc = 8'h11; a = 8'hA1; b = 8'hB2; dp = 8'hD3;
      x = 16'h1234; y = 16'h5678; us = 16'h9ABC; pc = 16'hC0DE;
      for (int i = 0; i < 65536; i++) begin
         bus_mem[i] = 8'(i ^ (i >> 8));
         mdl_mem[i] = 8'(i ^ (i >> 8));
      end
      repeat (3) @(posedge clk);
      #1 rst = 1'b0; cen = 1'b1;
      @(negedge clk);
      chk("rst_addr",     32'(addr),     32'd0);
      chk("rst_dout",     32'(dout),     32'd0);
      chk("rst_sp_out",   32'(sp_out),   32'd0);
      chk("rst_pul_sel",  32'(pul_sel),  32'd0);
      chk("rst_pul_hi",   32'(pul_hi),   32'd0);
      chk("rst_pul_data", 32'(pul_data), 32'd0);
      chk("rst_busy",     32'(busy),     32'd0);

      // Push PC,B,A from 0x0100
      build(1'b1, 8'h86, 16'h0100);
      chk("m1_n",  32'(exp_q.size()), 32'd4);
      chk("m1_b0", 32'({exp_q[0].addr, exp_q[0].data}), 32'h00FF_DE);
      chk("m1_b1", 32'({exp_q[1].addr, exp_q[1].data}), 32'h00FE_C0);
      chk("m1_b2", 32'({exp_q[2].addr, exp_q[2].data}), 32'h00FD_B2);
      chk("m1_b3", 32'({exp_q[3].addr, exp_q[3].data}), 32'h00FC_A1);
      chk("m1_sp", 32'(exp_sp), 32'h00FC);
      run(1'b1, 8'h86, 16'h0100, 1'b0, ncen);
      chk("push_done_lat", 32'(ncen), 32'd5);

      // Pull it back
      build(1'b0, 8'h86, 16'h00FC);
      chk("m2_b0", 32'({exp_q[0].sel, exp_q[0].hi, exp_q[0].data}), 32'({3'd1, 1'b0, 8'hA1}));
      chk("m2_b1", 32'({exp_q[1].sel, exp_q[1].hi, exp_q[1].data}), 32'({3'd2, 1'b0, 8'hB2}));
      chk("m2_b2", 32'({exp_q[2].sel, exp_q[2].hi, exp_q[2].data}), 32'({3'd7, 1'b1, 8'hC0}));
      chk("m2_b3", 32'({exp_q[3].sel, exp_q[3].hi, exp_q[3].data}), 32'({3'd7, 1'b0, 8'hDE}));
      chk("m2_sp", 32'(exp_sp), 32'h0100);
      run(1'b0, 8'h86, 16'h00FC, 1'b0, ncen);

      // Empty mask
      build(1'b1, 8'h00, 16'h1234);
      chk("m3_n",  32'(exp_q.size()), 32'd0);
      chk("m3_sp", 32'(exp_sp), 32'h1234);
      run(1'b1, 8'h00, 16'h1234, 1'b0, ncen);
      chk("empty_done_lat", 32'(ncen), 32'd1);

      // Pointer wrap on push
      build(1'b1, 8'h10, 16'h0001);
      chk("m4_b0", 32'({exp_q[0].addr, exp_q[0].data}), 32'h0000_34);
      chk("m4_b1", 32'({exp_q[1].addr, exp_q[1].data}), 32'hFFFF_12);
      chk("m4_sp", 32'(exp_sp), 32'hFFFF);
      run(1'b1, 8'h10, 16'h0001, 1'b0, ncen);

      // Full mask with cen toggling and a stray go while busy
      build(1'b1, 8'hFF, 16'h4000);
      chk("m5_n",  32'(exp_q.size()), 32'd12);
      chk("m5_sp", 32'(exp_sp), 32'h3FF4);
      run(1'b1, 8'hFF, 16'h4000, 1'b1, ncen);
      chk("toggle_cen_cnt", 32'(ncen), 32'd13);

      // Pull X from 0xFFFF, reset in the low-byte cycle
      build(1'b0, 8'h10, 16'hFFFF);
      @(posedge clk); #1;
      pul_go = 1'b1; mask = 8'h10; sp_in = 16'hFFFF; cen = 1'b1; arm = 1'b1;
      @(posedge clk); #1;
      pul_go = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("abort_busy",   32'(busy),   32'd0);
      chk("abort_sp_upd", 32'(sp_upd), 32'd0);
      chk("abort_rd",     32'(rd),     32'd0);
      repeat (2) @(posedge clk);

      // Clean pull across the wrap
      build(1'b0, 8'h10, 16'hFFFF);
      chk("m6_b0", 32'({exp_q[0].addr, exp_q[0].hi, exp_q[0].data}), 32'({16'hFFFF, 1'b1, 8'h12}));
      chk("m6_b1", 32'({exp_q[1].addr, exp_q[1].hi, exp_q[1].data}), 32'({16'h0000, 1'b0, 8'h34}));
      chk("m6_sp", 32'(exp_sp), 32'h0001);
      run(1'b0, 8'h10, 16'hFFFF, 1'b0, ncen);
      chk("pull_x_lat", 32'(ncen), 32'd3);

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
